lvds_frame_pack: RTL and testbench

LVDS_FRAME_PACK -- requirements
Module: lvds_frame_pack

---
 rtl/lvds_pkg.sv | 26 ++
 rtl/lvds_frame_pack_if.sv | 26 ++
 rtl/lvds_frame_pack_axis_out_reg.sv | 44 ++++
 rtl/lvds_frame_pack.sv | 155 +++++++++++++++
 tb/tb_lvds_frame_pack.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lvds_pkg.sv
// Shared types and defaults for the LVDS frame packer: FSM states, header
// field widths and the saturating beat-counter helper.
package lvds_pkg;

    localparam int          FRAME_NUM_DEFAULT = 1024;
    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hA5A5_5AA5;

    localparam int HDR_SEQ_W  = 16;
    localparam int HDR_LEN_W  = 16;
    localparam int SAMPLE_W   = 16;
    localparam int BEAT_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        PAYLOAD,
        FLUSH
    } state_e;

    // Beat counter sticks at all-ones so an overlong frame never aliases to a valid length.
    function automatic logic [BEAT_CNT_W-1:0] sat_inc(input logic [BEAT_CNT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/lvds_frame_pack_if.sv
// AXI4-Stream style bundle used for both the sample input and the packed output.
interface axis_if #(
    parameter int W = 32
);
    logic           TVALID;
    logic           TREADY;
    logic [W-1:0]   TDATA;
    logic           TLAST;
    logic [W/8-1:0] TSTRB;

    modport master (
        output TVALID,
        output TDATA,
        output TLAST,
        output TSTRB,
        input  TREADY
    );

    modport slave (
        input  TVALID,
        input  TDATA,
        input  TLAST,
        input  TSTRB,
        output TREADY
    );
endinterface

// File: rtl/lvds_frame_pack_axis_out_reg.sv
// One-entry registered output stage: breaks the TREADY->TVALID path while
// still accepting a new word every cycle when the sink keeps TREADY high.
module axis_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    axis_if.master       m
);

    logic         valid_q;
    logic [W-1:0] data_q;
    logic         last_q;

    assign in_ready = !valid_q || m.TREADY;

    assign m.TVALID = valid_q;
    assign m.TDATA  = data_q;
    assign m.TLAST  = last_q;
    assign m.TSTRB  = '1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            // NOTE: data and last are reset as well so the bus reads all-zero
            // while rst_n is low, not just invalid.
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
            last_q  <= in_last;
        end else if (m.TREADY) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/lvds_frame_pack.sv
// Packs pairs of 16-bit LVDS samples into 32-bit words, framing each packet
// with a sync word and a {sequence, length} header.
module lvds_frame_pack
    import lvds_pkg::*;
#(
    parameter int          FRAME_NUM          = FRAME_NUM_DEFAULT,
    parameter int          M_AXIS_TDATA_WIDTH = 32,
    parameter logic [31:0] SYNC_WORD          = SYNC_WORD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axis_if.slave                 S_AXIS,
    axis_if.master                M_AXIS,
    output logic [HDR_SEQ_W-1:0]  frame_cnt,
    output logic                  len_err,
    output logic                  busy
);

    if (M_AXIS_TDATA_WIDTH != 32 || FRAME_NUM < 2 || (FRAME_NUM % 2) != 0) begin : g_param_check
        $error("lvds_frame_pack: TDATA width must be 32 and FRAME_NUM even and >= 2");
    end

    localparam logic [HDR_LEN_W-1:0]  HDR_LEN   = HDR_LEN_W'(FRAME_NUM / 2);
    localparam logic [BEAT_CNT_W-1:0] FRAME_LEN = BEAT_CNT_W'(FRAME_NUM);

    state_e                  state_q;
    logic                    phase_q;
    logic                    flush_pend_q;
    logic                    len_err_q;
    logic [SAMPLE_W-1:0]     low_q;
    logic [BEAT_CNT_W-1:0]   beat_cnt_q;
    logic [BEAT_CNT_W-1:0]   beat_cnt_next;
    logic [HDR_SEQ_W-1:0]    seq_q;

    logic                    push;
    logic                    push_last;
    logic [31:0]             push_data;
    logic                    out_ready;
    logic                    s_ready;
    logic                    s_hs;
    logic                    m_hs;
    logic [SAMPLE_W-1:0]     sample;
    logic                    unused_tdata_hi;

    assign sample          = S_AXIS.TDATA[SAMPLE_W-1:0];
    assign unused_tdata_hi = ^{S_AXIS.TDATA[M_AXIS_TDATA_WIDTH-1:SAMPLE_W], S_AXIS.TSTRB};

    assign s_ready       = (state_q == PAYLOAD) && out_ready;
    assign S_AXIS.TREADY = s_ready;
    assign s_hs          = S_AXIS.TVALID && s_ready;
    assign m_hs          = M_AXIS.TVALID && M_AXIS.TREADY;
    assign beat_cnt_next = sat_inc(beat_cnt_q);

    assign frame_cnt = seq_q;
    assign len_err   = len_err_q;
    assign busy      = (state_q != IDLE);

    // Each header word is loaded only once the previous one has left the
    // output register, so HDR0/HDR1 track exactly which word is on the bus.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        push      = 1'b0;
        push_last = 1'b0;
        push_data = '0;
        unique case (state_q)
            IDLE: begin
                push      = S_AXIS.TVALID;
                push_data = SYNC_WORD;
            end
            HDR0: begin
                push      = m_hs;
                push_data = {seq_q, HDR_LEN};
            end
            PAYLOAD: begin
                push      = s_hs && phase_q;
                push_last = S_AXIS.TLAST;
                push_data = {sample, low_q};
            end
            FLUSH: begin
                push      = flush_pend_q;
                push_last = 1'b1;
                push_data = {16'h0000, low_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            len_err_q    <= 1'b0;
            low_q        <= '0;
            beat_cnt_q   <= '0;
            seq_q        <= '0;
        end else begin
            len_err_q <= 1'b0;
            if (m_hs && M_AXIS.TLAST) begin
                seq_q <= seq_q + 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    beat_cnt_q <= '0;
                    phase_q    <= 1'b0;
                    if (S_AXIS.TVALID && out_ready) begin
                        state_q <= HDR0;
                    end
                end
                HDR0: if (m_hs) state_q <= HDR1;
                HDR1: if (m_hs) state_q <= PAYLOAD;
                PAYLOAD: begin
                    if (s_hs) begin
                        phase_q    <= !phase_q;
                        beat_cnt_q <= S_AXIS.TLAST ? '0 : beat_cnt_next;
                        if (!phase_q) begin
                            low_q <= sample;
                        end
                        // The odd-beat TLAST word is already queued; an even
                        // TLAST still owes a zero-padded closing word.
                        if (S_AXIS.TLAST) begin
                            len_err_q    <= (beat_cnt_next != FRAME_LEN);
                            flush_pend_q <= !phase_q;
                            state_q      <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_pend_q && out_ready) begin
                        flush_pend_q <= 1'b0;
                    end
                    if (m_hs && M_AXIS.TLAST) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    axis_out_reg #(
        .W (M_AXIS_TDATA_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (push),
        .in_ready (out_ready),
        .in_data  (push_data),
        .in_last  (push_last),
        .m        (M_AXIS)
    );

endmodule

// File: tb/tb_lvds_frame_pack.sv
// Self-checking bench: a FRAME_NUM=4 instance driven from a vector table and a
// FRAME_NUM=1024 instance for throttled ramps, reset and counter wrap.
module tb_lvds_frame_pack;

    localparam logic [31:0] SYNC  = 32'hA5A5_5AA5;
    localparam int          BOUND = 4000;
    localparam int          N1K   = 12;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } word_t;

    typedef struct {
        int               n;
        logic [4:0][15:0] s;
        int               np;
        logic [2:0][31:0] p;
        int               lerr;
        int               rdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int pct4     = 100;
    int pct1k    = 100;
    int lerr4    = 0;
    int lerr1k   = 0;

    word_t exp4[$];
    word_t exp1k[$];

    axis_if #(.W(32)) s4 ();
    axis_if #(.W(32)) m4 ();
    axis_if #(.W(32)) s1k ();
    axis_if #(.W(32)) m1k ();

    logic [15:0] frame_cnt4, frame_cnt1k;
    logic        len_err4, len_err1k, busy4, busy1k;

    lvds_frame_pack #(.FRAME_NUM(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .S_AXIS    (s4),
        .M_AXIS    (m4),
        .frame_cnt (frame_cnt4),
        .len_err   (len_err4),
        .busy      (busy4)
    );

    lvds_frame_pack #(.FRAME_NUM(1024)) dut1k (
        .clk       (clk),
        .rst_n     (rst_n),
        .S_AXIS    (s1k),
        .M_AXIS    (m1k),
        .frame_cnt (frame_cnt1k),
        .len_err   (len_err1k),
        .busy      (busy1k)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: no progress within %0d cycles", name, BOUND);
    endtask

    function automatic word_t mkw(input logic [31:0] d, input logic l);
        word_t w;
        w.data = d;
        w.last = l;
        return w;
    endfunction

    function automatic vec_t mk(input int n, input logic [4:0][15:0] s, input int np,
                                input logic [2:0][31:0] p, input int lerr, input int rdy);
        vec_t v;
        v.n = n; v.s = s; v.np = np; v.p = p; v.lerr = lerr; v.rdy = rdy;
        return v;
    endfunction

    function automatic logic [15:0] ramp(input int f, input int b);
        return 16'(f * 4096 + b);
    endfunction

    // Sink back-pressure, redrawn every cycle just after the active edge.
    always @(posedge clk) begin
        #1;
        m4.TREADY  = (int'($urandom_range(99)) < pct4);
        m1k.TREADY = (int'($urandom_range(99)) < pct1k);
    end

    logic        stall4 = 1'b0, stall1k = 1'b0;
    logic [32:0] held4, held1k;

    always @(negedge clk) begin
        word_t w;
        if (!rst_n) begin
            stall4 = 1'b0;
        end else begin
            if (stall4) check("m4_stall", {m4.TVALID, m4.TLAST, m4.TDATA}, {1'b1, held4});
            if (m4.TVALID && m4.TREADY) begin
                if (exp4.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL m4_extra: got word 0x%0h, required none", m4.TDATA);
                end else begin
                    w = exp4.pop_front();
                    check("m4_word", {m4.TLAST, m4.TDATA}, {w.last, w.data});
                end
            end
            stall4 = m4.TVALID && !m4.TREADY;
            held4  = {m4.TLAST, m4.TDATA};
            if (len_err4) lerr4++;
        end
    end

    always @(negedge clk) begin
        word_t w;
        if (!rst_n) begin
            stall1k = 1'b0;
        end else begin
            if (stall1k) check("m1k_stall", {m1k.TVALID, m1k.TLAST, m1k.TDATA}, {1'b1, held1k});
            if (m1k.TVALID && m1k.TREADY) begin
                if (exp1k.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL m1k_extra: got word 0x%0h, required none", m1k.TDATA);
                end else begin
                    w = exp1k.pop_front();
                    check("m1k_word", {m1k.TLAST, m1k.TDATA}, {w.last, w.data});
                end
            end
            stall1k = m1k.TVALID && !m1k.TREADY;
            held1k  = {m1k.TLAST, m1k.TDATA};
            if (len_err1k) lerr1k++;
        end
    end

    // Called and returning at posedge+1; upper TDATA bits carry junk on purpose.
    task automatic send4(input logic [15:0] s, input logic last);
        bit ok;
        ok = 1'b0;
        s4.TVALID = 1'b1; s4.TDATA = {~s, s}; s4.TLAST = last;
        for (int c = 0; c < BOUND && !ok; c++) begin
            @(negedge clk); ok = s4.TREADY;
            @(posedge clk); #1;
        end
        s4.TVALID = 1'b0; s4.TLAST = 1'b0;
        if (!ok) timeout("send4");
    endtask

    task automatic send1k(input logic [15:0] s, input logic last);
        bit ok;
        ok = 1'b0;
        s1k.TVALID = 1'b1; s1k.TDATA = {s ^ 16'h5A5A, s}; s1k.TLAST = last;
        for (int c = 0; c < BOUND && !ok; c++) begin
            @(negedge clk); ok = s1k.TREADY;
            @(posedge clk); #1;
        end
        s1k.TVALID = 1'b0; s1k.TLAST = 1'b0;
        if (!ok) timeout("send1k");
    endtask

    task automatic wait_idle4();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < BOUND && !ok; c++) begin
            @(negedge clk); ok = (exp4.size() == 0) && !busy4;
        end
        @(posedge clk); #1;
        if (!ok) timeout("idle4");
    endtask

    task automatic wait_1k(input bit need_idle);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < BOUND && !ok; c++) begin
            @(negedge clk); ok = (exp1k.size() == 0) && (!need_idle || !busy1k);
        end
        @(posedge clk); #1;
        if (!ok) timeout("idle1k");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [6];
        vecs[0] = mk(4, {16'h0, 16'h0004, 16'h0003, 16'h0002, 16'h0001}, 2,
                     {32'h0, 32'h0004_0003, 32'h0002_0001}, 0, 100);
        vecs[1] = vecs[0];
        vecs[2] = mk(3, {16'h0, 16'h0, 16'h0003, 16'h0002, 16'h8001}, 2,
                     {32'h0, 32'h0000_0003, 32'h0002_8001}, 1, 100);
        vecs[3] = mk(2, {16'h0, 16'h0, 16'h0, 16'h8000, 16'h7FFF}, 1,
                     {32'h0, 32'h0, 32'h8000_7FFF}, 1, 50);
        vecs[4] = mk(5, {16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001}, 3,
                     {32'h0000_0005, 32'h0004_0003, 32'h0002_0001}, 1, 50);
        vecs[5] = mk(1, {16'h0, 16'h0, 16'h0, 16'h0, 16'hABCD}, 1,
                     {32'h0, 32'h0, 32'h0000_ABCD}, 1, 50);

        s4.TVALID = 1'b0;  s4.TDATA = '0;  s4.TLAST = 1'b0;  s4.TSTRB = 4'hF;
        s1k.TVALID = 1'b0; s1k.TDATA = '0; s1k.TLAST = 1'b0; s1k.TSTRB = 4'hF;
        m4.TREADY = 1'b0;  m1k.TREADY = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs4", {m4.TVALID, m4.TLAST, m4.TDATA, s4.TREADY, frame_cnt4, len_err4, busy4}, '0);
        check("reset_outputs1k", {m1k.TVALID, m1k.TLAST, m1k.TDATA, s1k.TREADY, frame_cnt1k, len_err1k, busy1k}, '0);
        check("tstrb4", m4.TSTRB, 4'hF);
        check("tstrb1k", m1k.TSTRB, 4'hF);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            pct4  = vecs[i].rdy;
            lerr4 = 0;
            exp4.push_back(mkw(SYNC, 1'b0));
            exp4.push_back(mkw({16'(i), 16'h0002}, 1'b0));
            for (int k = 0; k < vecs[i].np; k++) exp4.push_back(mkw(vecs[i].p[k], k == vecs[i].np - 1));
            for (int b = 0; b < vecs[i].n; b++) begin
                send4(vecs[i].s[b], b == vecs[i].n - 1);
                if (vecs[i].rdy == 100 && (b % 2) == 1)
                    check("odd_beat_latency", {m4.TVALID, m4.TDATA}, {1'b1, vecs[i].p[b / 2]});
            end
            wait_idle4();
            check("len_err_pulses4", lerr4, vecs[i].lerr);
            check("frame_cnt4", frame_cnt4, 16'(i + 1));
        end

        // Throttled 1024-sample ramps against the scoreboard.
        pct1k = 30;
        for (int f = 0; f < N1K; f++) begin
            exp1k.push_back(mkw(SYNC, 1'b0));
            exp1k.push_back(mkw({16'(f), 16'h0200}, 1'b0));
            for (int b = 0; b < 1024; b += 2) exp1k.push_back(mkw({ramp(f, b + 1), ramp(f, b)}, b == 1022));
            for (int b = 0; b < 1024; b++) send1k(ramp(f, b), b == 1023);
            wait_1k(1'b1);
        end
        check("frame_cnt1k_ramps", frame_cnt1k, 16'(N1K));
        check("len_err1k_ramps", lerr1k, 0);

        // Reset in the middle of a packet after five payload words.
        pct1k = 100;
        exp1k.push_back(mkw(SYNC, 1'b0));
        exp1k.push_back(mkw({16'(N1K), 16'h0200}, 1'b0));
        for (int b = 0; b < 10; b += 2) exp1k.push_back(mkw({ramp(20, b + 1), ramp(20, b)}, 1'b0));
        for (int b = 0; b < 10; b++) send1k(ramp(20, b), 1'b0);
        wait_1k(1'b0);
        check("busy_mid_packet", busy1k, 1'b1);
        rst_n = 1'b0;
        exp1k.delete();
        #1;
        check("async_reset_outputs1k", {m1k.TVALID, m1k.TLAST, m1k.TDATA, s1k.TREADY, frame_cnt1k, len_err1k, busy1k}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        lerr1k = 0;
        exp1k.push_back(mkw(SYNC, 1'b0));
        exp1k.push_back(mkw(32'h0000_0200, 1'b0));
        exp1k.push_back(mkw(32'h0002_0001, 1'b1));
        send1k(16'h0001, 1'b0);
        send1k(16'h0002, 1'b1);
        wait_1k(1'b1);
        check("frame_cnt_after_reset", frame_cnt1k, 16'h0001);
        check("len_err_short_frame", lerr1k, 1);

        // Sequence counter wrap.
        force dut1k.seq_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut1k.seq_q;
        check("frame_cnt_preload", frame_cnt1k, 16'hFFFF);
        exp1k.push_back(mkw(SYNC, 1'b0));
        exp1k.push_back(mkw(32'hFFFF_0200, 1'b0));
        exp1k.push_back(mkw(32'h8002_0001, 1'b1));
        send1k(16'h0001, 1'b0);
        send1k(16'h8002, 1'b1);
        wait_1k(1'b1);
        check("frame_cnt_wrap", frame_cnt1k, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
